// File: rtl/fila_ctrl.sv
// fila_ctrl: round-robin req/ack arbiter (P0 -> P1 -> C) for the fila port; ack 1 cycle after grant, 1 op per 3 cycles.
// Producers stall while full, consumer while empty; define FILA_CTRL_STATS_EN for enq/deq counters and a sticky stall flag.
module fila_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             p0_req,
  input  logic [WIDTH-1:0] p0_data,
  output logic             p0_ack,
  input  logic             p1_req,
  input  logic [WIDTH-1:0] p1_data,
  output logic             p1_ack,
  input  logic             c_req,
  output logic [WIDTH-1:0] c_data,
  output logic             c_ack,
  output logic [WIDTH-1:0] q_data_in,
  output logic             q_enqueue,
  output logic             q_dequeue,
  input  logic [WIDTH-1:0] q_data_out,
  input  logic [7:0]       q_len,
  output logic             full,
  output logic             empty
`ifdef FILA_CTRL_STATS_EN
  ,
  output logic [15:0]      enq_count,
  output logic [15:0]      deq_count,
  output logic             stall_seen
`endif
);

  typedef enum logic [1:0] {IDLE, ENQ, DEQ, SETTLE} state_t;
  typedef enum logic [1:0] {SEL_P0, SEL_P1, SEL_C} sel_t;

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  state_t           state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             pick;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] c_data_q, c_data_d;
  logic             who_q, who_d;
  logic             full_q, empty_q;
  logic             prod_ok, cons_ok;
  logic [2:0]       elig;

  assign prod_ok = (q_len < DEPTH_L);
  assign cons_ok = (q_len != 8'd0);
  assign elig    = {c_req & cons_ok, p1_req & prod_ok, p0_req & prod_ok};

  // Priority search starting at the pointer; the last candidate is only reached when it is the sole eligible one.
  always_comb begin
    pick = SEL_P0;
    case (ptr_q)
      SEL_P1:  pick = elig[1] ? SEL_P1 : (elig[2] ? SEL_C  : SEL_P0);
      SEL_C:   pick = elig[2] ? SEL_C  : (elig[0] ? SEL_P0 : SEL_P1);
      default: pick = elig[0] ? SEL_P0 : (elig[1] ? SEL_P1 : SEL_C);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    who_d    = who_q;
    c_data_d = c_data_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          case (pick)
            SEL_P0:  ptr_d = SEL_P1;
            SEL_P1:  ptr_d = SEL_C;
            default: ptr_d = SEL_P0;
          endcase
          case (pick)
            SEL_P0: begin
              hold_d  = p0_data;
              who_d   = 1'b0;
              state_d = ENQ;
            end
            SEL_P1: begin
              hold_d  = p1_data;
              who_d   = 1'b1;
              state_d = ENQ;
            end
            default: begin
              // Head is captured at grant so c_data is already valid while c_ack is high.
              c_data_d = q_data_out;
              state_d  = DEQ;
            end
          endcase
        end
      end
      ENQ:     state_d = SETTLE;
      DEQ:     state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= SEL_P0;
      hold_q   <= '0;
      who_q    <= 1'b0;
      c_data_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      who_q    <= who_d;
      c_data_q <= c_data_d;
      full_q   <= (q_len == DEPTH_L);
      empty_q  <= (q_len == 8'd0);
    end
  end

  assign q_enqueue = (state_q == ENQ);
  assign q_dequeue = (state_q == DEQ);
  assign q_data_in = hold_q;
  assign p0_ack    = q_enqueue & ~who_q;
  assign p1_ack    = q_enqueue & who_q;
  assign c_ack     = q_dequeue;
  assign c_data    = c_data_q;
  assign full      = full_q;
  assign empty     = empty_q;

`ifdef FILA_CTRL_STATS_EN
  logic [15:0] enq_cnt_q, deq_cnt_q;
  logic        stall_q;

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      enq_cnt_q <= '0;
      deq_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (q_enqueue && enq_cnt_q != 16'hFFFF) enq_cnt_q <= enq_cnt_q + 16'd1;
      if (q_dequeue && deq_cnt_q != 16'hFFFF) deq_cnt_q <= deq_cnt_q + 16'd1;
      if (((p0_req | p1_req) & ~prod_ok) | (c_req & ~cons_ok)) stall_q <= 1'b1;
    end
  end

  assign enq_count  = enq_cnt_q;
  assign deq_count  = deq_cnt_q;
  assign stall_seen = stall_q;
`endif

endmodule

// File: doc/fila_ctrl.md
Name: fila_ctrl

Overview:
- Arbiter/sequencer in front of the 8-entry `fila` queue.
- Shares the queue's single enqueue/dequeue port between two producers and one consumer using req/ack handshakes and round-robin arbitration.
- Generates the one-cycle `enqueue_in`/`dequeue_in` strobes `fila` expects, and tracks occupancy from `len_out` so overflow and underflow never reach the queue.

Parameters:
- WIDTH, 8, data width of the queue entries and the requester data buses.
- DEPTH, 8, queue capacity; must match the `fila` instance.

Ports:
- clk_10KHz  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-high reset; tied to the same net as the `fila` reset.
- p0_req  input  1  producer 0 requests an enqueue.
- p0_data  input  WIDTH  producer 0 data.
- p0_ack  output  1  one-cycle pulse: p0_data was written.
- p1_req  input  1  producer 1 requests an enqueue.
- p1_data  input  WIDTH  producer 1 data.
- p1_ack  output  1  one-cycle pulse: p1_data was written.
- c_req  input  1  consumer requests a dequeue.
- c_data  output  WIDTH  dequeued value; registered, held until the next dequeue.
- c_ack  output  1  one-cycle pulse: c_data is valid and new.
- q_data_in  output  WIDTH  to `fila.data_in`.
- q_enqueue  output  1  to `fila.enqueue_in`.
- q_dequeue  output  1  to `fila.dequeue_in`.
- q_data_out  input  WIDTH  from `fila.data_out`; presents the head entry combinationally.
- q_len  input  8  from `fila.len_out`.
- full  output  1  registered; 1 when q_len == DEPTH.
- empty  output  1  registered; 1 when q_len == 0.

Behaviour:
- Reset values:
  - All outputs are 0 except empty = 1.
  - FSM is in IDLE.
  - The round-robin pointer is at P0.
  - c_data = 0.
- FSM states: IDLE, ENQ, DEQ, SETTLE.
- IDLE: sample the requests and select an eligible requester.
  - Producers are eligible only if q_len < DEPTH.
  - The consumer is eligible only if q_len > 0.
  - Round-robin order is P0 → P1 → C; the search starts at the pointer.
  - On a grant, the pointer moves to the entry after the granted one.
  - A producer grant latches that producer's data into the internal hold register, then goes to ENQ.
  - A consumer grant goes to DEQ.
  - With no eligible request, stay in IDLE.
- ENQ (exactly 1 cycle):
  - q_enqueue = 1 and q_data_in = hold register.
  - The granted producer's ack = 1 in the same cycle.
  - Next state is SETTLE.
- DEQ (exactly 1 cycle):
  - q_dequeue = 1.
  - c_data <= q_data_out, captured before the queue advances.
  - c_ack = 1 in the same cycle.
  - Next state is SETTLE.
- SETTLE (1 cycle): no strobes; lets q_len update; next state is IDLE.
- Latency: a request seen at IDLE edge N gets its ack in cycle N+1. Peak throughput is one operation per 3 cycles.
- Handshake rules:
  - A requester holds req (and data) until it sees ack.
  - Data is captured at grant, so changing data after grant has no effect.
  - req deasserted before grant is treated as withdrawn.
  - req still high in the cycle after ack counts as a new request.
- q_data_in holds its last value when q_enqueue = 0. q_enqueue and q_dequeue are never high together.
- full and empty are updated every cycle from q_len.
- Boundaries:
  - Full queue: producers stall indefinitely with no ack; the consumer is still served.
  - Empty queue: the consumer stalls; producers are still served.
  - Pointer wraps C → P0.
  - Simultaneous p0_req, p1_req and c_req are resolved strictly by the pointer, with no starvation: each requester waits at most 2 other grants.
- Reset asserted mid-operation, in any state: at the next edge the FSM returns to IDLE, and all strobes and acks drop to 0 in that cycle. An in-flight ENQ/DEQ is abandoned; the queue is cleared by the shared reset.

Optional Feature:
- Macro: FILA_CTRL_STATS_EN.
- When defined, adds 16-bit outputs enq_count and deq_count plus a 1-bit output stall_seen.
  - enq_count and deq_count increment on each q_enqueue / q_dequeue strobe and saturate at 16'hFFFF.
  - stall_seen is a sticky flag set when any req is held while its side is blocked (full for producers, empty for consumer).
  - All three are cleared by reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Enqueue/dequeue basic:
  - Stimulus: after reset, p0_req with data 8'h11.
  - Response: p0_ack one cycle after grant, q_enqueue pulse with q_data_in = 8'h11, then q_len = 1 and empty = 0.
  - Follow with c_req: c_ack pulse with c_data = 8'h11, q_len = 0, empty = 1.
- Round-robin fairness:
  - Stimulus: p0_req and p1_req held together with 8'hAA / 8'hBB for 4 grants.
  - Response: enqueue order AA, BB, AA, BB; acks alternate.
- Full stall:
  - Stimulus: p0 enqueues 8'h11..8'h88, then 8'h99 is requested.
  - Response: full = 1 and no p0_ack; a c_req is granted and returns c_data = 8'h11; 8'h99 is then accepted and q_len = 8.
- Empty stall:
  - Stimulus: c_req right after reset.
  - Response: no c_ack and no q_dequeue for 20 cycles; a later p1_req with 8'h5A gives p1_ack, then c_ack with c_data = 8'h5A.
- Three-way contention:
  - Stimulus: queue holds 8'h01, then p0, p1 and c request simultaneously.
  - Response: grant order P0, P1, C; c_data = 8'h01; each ack is 3 cycles apart.
- Reset mid-op:
  - Stimulus: assert reset during the ENQ cycle.
  - Response: next cycle state is IDLE, all strobes and acks are 0, empty = 1, c_data = 0, and the pointer is at P0 (the next contended grant goes to P0).
